// File: rtl/key_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : key_command_sequencer
//  Description : Decodes PS/2 set-2 scan codes into glyph-select and
//                offset-step requests, holds them pending and issues them as
//                single-cycle strobes only at frame start so that glyph and
//                offset changes never tear mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_command_sequencer #(
    parameter int unsigned REPEAT_FRAMES = 4
) (
    input  logic       Pixelclock,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       vsync_start,
    output logic [7:0] character,
    output logic       char_check,
    output logic       move_check,
    output logic       key_held
);

    // ------------------------------------------------------------------
    // Scan-code constants
    // ------------------------------------------------------------------
    localparam logic [7:0] c_CODE_BREAK = 8'hF0;
    localparam logic [7:0] c_CODE_EXT   = 8'hE0;
    localparam logic [7:0] c_GLYPH_F    = 8'h2B;
    localparam logic [7:0] c_GLYPH_Q    = 8'h15;
    localparam logic [7:0] c_GLYPH_H    = 8'h33;
    localparam logic [7:0] c_GLYPH_X    = 8'h22;
    localparam logic [7:0] c_MOVE_I     = 8'h43;
    localparam logic [7:0] c_MOVE_K     = 8'h42;
    localparam logic [7:0] c_MOVE_J     = 8'h3B;
    localparam logic [7:0] c_MOVE_L     = 8'h4B;
    // Counter value loaded after a move fires; the next move is that many
    // frames later plus the firing frame itself.
    localparam logic [7:0] c_RELOAD     = 8'(REPEAT_FRAMES - 1);

    // Byte-sequence decoder states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_is_glyph;
    logic       w_is_move;
    logic       w_glyph_hit;
    logic       w_move_press;
    logic       w_move_release;

    logic [7:0] r_pend_char;
    logic       r_char_pend;
    logic [7:0] r_held_move;
    logic       r_key_held;
    logic [7:0] r_rep_cnt;

    logic       w_issue_char;
    logic       w_fire;

    logic [7:0] r_character;
    logic       r_char_check;
    logic       r_move_check;
    logic       r_move_defer;
    logic [7:0] r_defer_code;

    // ------------------------------------------------------------------
    // Reset synchroniser: asserts immediately, releases on the clock
    // ------------------------------------------------------------------
    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Code classification
    // ------------------------------------------------------------------
    assign w_is_glyph = (scan_code == c_GLYPH_F) || (scan_code == c_GLYPH_Q) ||
                        (scan_code == c_GLYPH_H) || (scan_code == c_GLYPH_X);
    assign w_is_move  = (scan_code == c_MOVE_I)  || (scan_code == c_MOVE_K)  ||
                        (scan_code == c_MOVE_J)  || (scan_code == c_MOVE_L);

    // Frame-start issue decisions, taken from pre-edge request state
    assign w_issue_char = vsync_start && r_char_pend;
    assign w_fire       = vsync_start && r_key_held && (r_rep_cnt == 8'd0);

    // Decoder state register
    always_ff @(posedge Pixelclock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Decoder next-state and request decode
    always_comb begin
        w_next_state   = r_state;
        w_glyph_hit    = 1'b0;
        w_move_press   = 1'b0;
        w_move_release = 1'b0;
        if (scan_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (scan_code == c_CODE_BREAK) begin
                        w_next_state = ST_BREAK;
                    end else if (scan_code == c_CODE_EXT) begin
                        w_next_state = ST_EXT;
                    end else if (w_is_glyph) begin
                        w_glyph_hit = 1'b1;
                    end else if (w_is_move && (!r_key_held || (scan_code != r_held_move))) begin
                        // Typematic repeats of the held key are dropped here
                        w_move_press = 1'b1;
                    end
                end
                ST_BREAK: begin
                    w_next_state   = ST_IDLE;
                    w_move_release = r_key_held && (scan_code == r_held_move);
                end
                ST_EXT: begin
                    w_next_state = (scan_code == c_CODE_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                end
                ST_EXT_BREAK: begin
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Pending glyph request; a new glyph wins over the clear of an issue
    always_ff @(posedge Pixelclock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pend_char <= 8'h00;
            r_char_pend <= 1'b0;
        end else if (w_glyph_hit) begin
            r_pend_char <= scan_code;
            r_char_pend <= 1'b1;
        end else if (w_issue_char) begin
            r_char_pend <= 1'b0;
        end
    end

    // Held movement key and frame repeat counter
    always_ff @(posedge Pixelclock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_held_move <= 8'h00;
            r_key_held  <= 1'b0;
            r_rep_cnt   <= 8'd0;
        end else if (w_move_press) begin
            r_held_move <= scan_code;
            r_key_held  <= 1'b1;
            r_rep_cnt   <= 8'd0;
        end else if (w_move_release) begin
            r_key_held  <= 1'b0;
            r_rep_cnt   <= 8'd0;
        end else if (vsync_start && r_key_held) begin
            if (r_rep_cnt == 8'd0) begin
                r_rep_cnt <= c_RELOAD;
            end else begin
                r_rep_cnt <= r_rep_cnt - 8'd1;
            end
        end
    end

    // Strobe generation; a move colliding with a glyph slips one cycle
    always_ff @(posedge Pixelclock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_character  <= 8'h00;
            r_char_check <= 1'b0;
            r_move_check <= 1'b0;
            r_move_defer <= 1'b0;
            r_defer_code <= 8'h00;
        end else begin
            r_char_check <= w_issue_char;
            r_move_check <= (w_fire && !w_issue_char) || r_move_defer;
            r_move_defer <= w_fire && w_issue_char;
            if (w_fire) begin
                r_defer_code <= r_held_move;
            end
            if (w_issue_char) begin
                r_character <= r_pend_char;
            end else if (w_fire) begin
                r_character <= r_held_move;
            end else if (r_move_defer) begin
                r_character <= r_defer_code;
            end
        end
    end

    assign character  = r_character;
    assign char_check = r_char_check;
    assign move_check = r_move_check;
    assign key_held   = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_key_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_command_sequencer
//  Description : Self-checking bench for key_command_sequencer. Directed
//                scenarios plus random byte/frame traffic, all compared
//                against a frame-indexed behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_command_sequencer;

    localparam int c_R = 4;

    logic       Pixelclock  = 1'b0;
    logic       reset       = 1'b1;
    logic       scan_valid  = 1'b0;
    logic [7:0] scan_code   = 8'h00;
    logic       vsync_start = 1'b0;
    logic [7:0] character;
    logic       char_check;
    logic       move_check;
    logic       key_held;

    key_command_sequencer #(.REPEAT_FRAMES(c_R)) u_dut (
        .Pixelclock  (Pixelclock),
        .reset       (reset),
        .scan_valid  (scan_valid),
        .scan_code   (scan_code),
        .vsync_start (vsync_start),
        .character   (character),
        .char_check  (char_check),
        .move_check  (move_check),
        .key_held    (key_held)
    );

    always #5 Pixelclock = ~Pixelclock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: -1 means "nothing"
    int         m_pend;     // pending glyph code
    int         m_held;     // held movement code
    int         m_idx;      // frames seen since the held key was pressed
    int         m_defer;    // move code due one cycle late
    bit         m_brk;      // inside a break sequence
    bit         m_ext;      // inside an extended sequence
    logic [7:0] m_char;     // last character presented
    int         n_moves = 0;
    int         n_chars = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_glyph(input logic [7:0] c);
        return (c == 8'h2B) || (c == 8'h15) || (c == 8'h33) || (c == 8'h22);
    endfunction

    function automatic bit is_move(input logic [7:0] c);
        return (c == 8'h43) || (c == 8'h42) || (c == 8'h3B) || (c == 8'h4B);
    endfunction

    task automatic model_reset();
        m_pend  = -1;
        m_held  = -1;
        m_idx   = 0;
        m_defer = -1;
        m_brk   = 1'b0;
        m_ext   = 1'b0;
        m_char  = 8'h00;
    endtask

    // One clock cycle: drive inputs, advance the model, compare outputs
    task automatic step(input bit sv, input logic [7:0] code, input bit vs);
        bit issue;
        bit fire;
        bit e_cc;
        bit e_mc;
        scan_valid  = sv;
        scan_code   = code;
        vsync_start = vs;
        @(posedge Pixelclock);
        issue = vs && (m_pend >= 0);
        fire  = vs && (m_held >= 0) && ((m_idx % c_R) == 0);
        e_cc  = issue;
        e_mc  = (fire && !issue) || (m_defer >= 0);
        if (issue)             m_char = m_pend[7:0];
        else if (fire)         m_char = m_held[7:0];
        else if (m_defer >= 0) m_char = m_defer[7:0];
        m_defer = (fire && issue) ? m_held : -1;
        if (issue) m_pend = -1;
        if (vs && (m_held >= 0)) m_idx++;
        if (sv) begin
            if (m_brk) begin
                if (!m_ext && (int'(code) == m_held)) m_held = -1;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end else if (m_ext) begin
                if (code == 8'hF0) m_brk = 1'b1;
                else               m_ext = 1'b0;
            end else if (code == 8'hF0) begin
                m_brk = 1'b1;
            end else if (code == 8'hE0) begin
                m_ext = 1'b1;
            end else if (is_glyph(code)) begin
                m_pend = int'(code);
            end else if (is_move(code) && (int'(code) != m_held)) begin
                m_held = int'(code);
                m_idx  = 0;
            end
        end
        #1;
        check("char_check", {31'd0, char_check}, {31'd0, e_cc});
        check("move_check", {31'd0, move_check}, {31'd0, e_mc});
        check("character",  {24'd0, character},  {24'd0, m_char});
        check("key_held",   {31'd0, key_held},   {31'd0, (m_held >= 0)});
        if (move_check) n_moves++;
        if (char_check) n_chars++;
        scan_valid  = 1'b0;
        vsync_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] code);
        step(1'b1, code, 1'b0);
    endtask

    task automatic frame();
        step(1'b0, 8'h00, 1'b1);
        idle(3);
    endtask

    // Asynchronous reset between clock edges, then a synchronised release
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_character",  {24'd0, character},  32'h0);
        check("rst_char_check", {31'd0, char_check}, 32'h0);
        check("rst_move_check", {31'd0, move_check}, 32'h0);
        check("rst_key_held",   {31'd0, key_held},   32'h0);
        idle(3);
        reset = 1'b1;
        idle(4);
    endtask

    initial begin
        int since_vs;
        int sel;
        logic [7:0] b;
        bit do_vs;

        model_reset();
        #1;
        do_reset();

        // Glyph issued one cycle after frame start, no move
        n_chars = 0; n_moves = 0;
        send(8'h2B);
        idle(85);
        frame();
        check("t1_chars", n_chars, 1);
        check("t1_moves", n_moves, 0);

        // Held movement repeats every c_R frames, stops on release
        n_moves = 0;
        send(8'h4B);
        repeat (10) frame();
        check("t2_moves10", n_moves, 3);
        send(8'hF0);
        send(8'h4B);
        repeat (4) frame();
        check("t2_after_release", n_moves, 3);

        // Glyph/move collision: move slips one cycle
        n_chars = 0; n_moves = 0;
        send(8'h15);
        send(8'h43);
        frame();
        check("t3_chars", n_chars, 1);
        check("t3_moves", n_moves, 1);
        send(8'hF0);
        send(8'h43);
        idle(2);

        // Break and extended sequences never act
        send(8'hF0); send(8'h33);
        send(8'hE0); send(8'h4B);
        send(8'hE0); send(8'hF0); send(8'h4B);
        n_chars = 0; n_moves = 0;
        repeat (3) frame();
        check("t4_no_chars", n_chars, 0);
        check("t4_no_moves", n_moves, 0);
        send(8'h22);
        frame();
        check("t4_idle_again", n_chars, 1);

        // Overwrite, then a glyph arriving with the issuing frame start
        n_chars = 0;
        send(8'h2B);
        send(8'h22);
        frame();
        check("t5_overwrite", n_chars, 1);
        send(8'h2B);
        step(1'b1, 8'h33, 1'b1);
        idle(3);
        frame();
        check("t5_simul", n_chars, 3);

        // Release in the same cycle as frame start still fires
        n_moves = 0;
        send(8'h3B);
        repeat (4) frame();
        send(8'hF0);
        step(1'b1, 8'h3B, 1'b1);
        idle(3);
        check("t6_release_fire", n_moves, 2);

        // Async reset while a move key is held
        send(8'h42);
        frame();
        idle(2);
        do_reset();
        n_moves = 0;
        frame();
        check("t7_no_move", n_moves, 0);

        // Random traffic
        since_vs = 10;
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 13));
            case (sel)
                0, 1, 2, 3: b = (sel == 0) ? 8'h2B : (sel == 1) ? 8'h15 : (sel == 2) ? 8'h33 : 8'h22;
                4, 5, 6, 7: b = (sel == 4) ? 8'h43 : (sel == 5) ? 8'h42 : (sel == 6) ? 8'h3B : 8'h4B;
                8, 9:       b = 8'hF0;
                10:         b = 8'hE0;
                11:         b = 8'($urandom_range(0, 255));
                default:    b = 8'h00;
            endcase
            do_vs = (since_vs >= 3) && ($urandom_range(0, 5) == 0);
            step((sel <= 11), b, do_vs);
            since_vs = do_vs ? 0 : since_vs + 1;
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_command_sequencer.md
# key_command_sequencer

Sequences keyboard commands into the glyph mask datapath. It decodes the PS/2 set-2 scan-code byte stream, tracks make and break codes, and holds glyph and movement requests pending. It then issues them as single-cycle `char_check` / `move_check` strobes with a matching `character` code, only at frame start, so glyph and offset changes never tear mid-frame. It sits between the PS/2 byte receiver and the mask producer, in the `Pixelclock` domain.

## Interface
- `REPEAT_FRAMES`, 4: frames between successive moves while a movement key is held; legal range 1–255.
- `Pixelclock`  in  1  pixel clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `scan_valid`  in  1  one-cycle strobe: `scan_code` holds a new byte.
- `scan_code`  in  8  PS/2 set-2 byte.
- `vsync_start`  in  1  one-cycle strobe at the first blanking line of each frame.
- `character`  out  8  code presented with the strobes.
- `char_check`  out  1  one-cycle glyph-select strobe.
- `move_check`  out  1  one-cycle offset-step strobe.
- `key_held`  out  1  high while a movement key is held.

## Operation
- Glyph codes: 0x2B F, 0x15 Q, 0x33 H, 0x22 X.
- Movement codes: 0x43 I, 0x42 K, 0x3B J, 0x4B L.
- All other codes are ignored.
- Decoder FSM, advanced only on `scan_valid`:
  - IDLE:
    - 0xF0 → BREAK.
    - 0xE0 → EXT.
    - Glyph code → set `pend_char` = code and `char_pend` = 1. The latest glyph overwrites any unissued one.
    - Movement code different from `held_move`, or no key held → `held_move` = code, `key_held` = 1, `rep_cnt` = 0 (fires at the next frame).
    - Same movement code again (keyboard typematic) → ignored.
    - Other codes → ignored.
  - BREAK: byte equal to `held_move` → `key_held` = 0, `rep_cnt` = 0. Any other byte is consumed. Always → IDLE.
  - EXT: 0xF0 → EXT_BREAK. Any other byte is consumed → IDLE. Extended keys are never acted on.
  - EXT_BREAK: byte consumed → IDLE.
- Issue logic, on the edge sampling `vsync_start` = 1, using state from before that edge:
  - If `char_pend`: next cycle `char_check` = 1 and `character` = `pend_char`; `char_pend` clears.
  - If `key_held` and `rep_cnt` = 0: a move fires and `rep_cnt` reloads to REPEAT_FRAMES−1.
  - Else if `key_held`: `rep_cnt` decrements.
  - A fired move drives `move_check` = 1 and `character` = `held_move`:
    - in the cycle after `vsync_start` when no char is issued that frame;
    - one cycle later when a char is issued that frame, so the strobes never overlap.
- `character` keeps its last driven value between strobes.

## Timing
- Reset (`reset` = 0, asynchronous): `character` = 0x00, `char_check` = 0, `move_check` = 0, `key_held` = 0, FSM = IDLE, `char_pend` = 0, `rep_cnt` = 0.
- Release of reset is synchronised internally; outputs are stable by the first rising edge after release.
- Strobe latency from `vsync_start`: 1 cycle for `char_check`, 1 or 2 cycles for `move_check`. Each strobe is exactly one cycle wide.
- Scan decode latency: 1 cycle. Requests set in the same cycle as `vsync_start` wait for the next frame.
- `scan_valid` and `vsync_start` in the same cycle, while the char being issued clears `char_pend`: a newly arriving glyph remains pending (set wins over clear).
- Release and `vsync_start` in the same cycle: the move still fires that frame (pre-edge state is used).
- A press of a different movement key replaces the held key. The release of the old key is then ignored because it no longer matches `held_move`.
- `rep_cnt` is 8 bits and never wraps below 0; it reloads only on a fire.
- With REPEAT_FRAMES = 1, a move fires every frame.
- Reset mid-sequence (e.g. in BREAK) discards pending requests and the partial byte sequence.

## Test plan
- Reset, then glyph: assert reset, release, send 0x2B, pulse `vsync_start` at cycle 100 → `char_check` high only at cycle 101 with `character` = 0x2B; no `move_check`.
- Held movement: REPEAT_FRAMES = 4, send 0x4B, 10 vsync pulses → `move_check` with 0x4B after vsync 1, 5, 9 only; send 0xF0 0x4B → `key_held` = 0, no further moves.
- Collision: send 0x15 then 0x43 before one vsync at cycle N → `char_check`/0x15 at N+1, `move_check`/0x43 at N+2.
- Break and extended filtering: send 0xF0 0x33, then 0xE0 0x4B, then 0xE0 0xF0 0x4B → no strobes across 3 frames, FSM back in IDLE (a following 0x22 issues normally).
- Overwrite and simultaneity: send 0x2B then 0x22 → only 0x22 issued. Send 0x33 in the same cycle as the vsync issuing a prior char → 0x33 issued at the following frame.
- Async reset mid-operation: hold 0x42, pulse `reset` low between vsyncs → all outputs 0 immediately, no move at the next vsync.
